// File: rtl/cpc_bus_initiator.sv
// Purpose: Z80-style bus-cycle initiator that turns one host request into one CPC memory or IO read/write cycle.
// Latency: accept edge to rsp_valid is 4 cycles for memory and 4+IO_WAIT for IO; each READY wait state adds 1.
// Backpressure: req_ready is high only in IDLE, including the rsp_valid cycle. READY low stretches the cycle up to MAX_WAIT waits, then the cycle aborts.
//
// Ports:
//   CLK, RESET_B             bus clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready      host handshake; req_io, req_wr, req_addr, req_wdata are latched on accept
//   rsp_valid/rsp_rdata/rsp_err
//                            one-cycle completion pulse with read data, or the abort flag
//   A, D_OUT, D_OE, D_IN     address bus and split data bus
//   MREQ_B, IOREQ_B, RD_B, WR_B
//                            active-low cycle strobes
//   M1_B, RFSH_B             tied high
//   READY                    low requests a wait state
module cpc_bus_initiator #(
    parameter int IO_WAIT  = 1,
    parameter int MAX_WAIT = 16
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_io,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    output logic        MREQ_B,
    output logic        IOREQ_B,
    output logic        RD_B,
    output logic        WR_B,
    output logic        M1_B,
    output logic        RFSH_B,
    input  logic        READY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TWA,
        S_TW,
        S_T3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       io_q;
    logic       wr_q;
    logic       accept;
    logic       done_ok;
    logic       done_err;
    logic       wr_eff;
    logic       strb_nxt;

    assign req_ready = (state == S_IDLE);
    assign M1_B      = 1'b1;
    assign RFSH_B    = 1'b1;

    // wait_cnt is shared: it counts the automatic IO waits in TWA, then restarts at zero to count READY waits in TW.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        done_ok      = 1'b0;
        done_err     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_T1;
                end
            end
            S_T1: state_nxt = S_T2;
            S_T2: begin
                wait_cnt_nxt = 8'd0;
                if (io_q && (IO_WAIT > 0)) begin
                    state_nxt = S_TWA;
                end else begin
                    state_nxt = READY ? S_T3 : S_TW;
                end
            end
            S_TWA: begin
                if (wait_cnt == 8'(IO_WAIT - 1)) begin
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = READY ? S_T3 : S_TW;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_TW: begin
                if (READY) begin
                    state_nxt = S_T3;
                end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                    // This is the last allowed wait state, so abort the cycle.
                    state_nxt = S_IDLE;
                    done_err  = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_T3: begin
                state_nxt = S_IDLE;
                done_ok   = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The bus outputs are decoded from the next state and then registered, so the strobes are glitch-free.
    // During the accept cycle the direction comes from the request, because wr_q is not loaded yet.
    assign wr_eff   = accept ? req_wr : wr_q;
    assign strb_nxt = (state_nxt == S_T2) || (state_nxt == S_TWA) ||
                      (state_nxt == S_TW) || (state_nxt == S_T3);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            io_q      <= 1'b0;
            wr_q      <= 1'b0;
            A         <= 16'h0000;
            D_OUT     <= 8'h00;
            D_OE      <= 1'b0;
            MREQ_B    <= 1'b1;
            IOREQ_B   <= 1'b1;
            RD_B      <= 1'b1;
            WR_B      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                io_q <= req_io;
                wr_q <= req_wr;
                A    <= req_addr;
                if (req_wr) begin
                    D_OUT <= req_wdata;
                end
            end
            D_OE      <= (state_nxt != S_IDLE) && wr_eff;
            MREQ_B    <= !(strb_nxt && !io_q);
            IOREQ_B   <= !(strb_nxt && io_q);
            RD_B      <= !(strb_nxt && !wr_q);
            WR_B      <= !(strb_nxt && wr_q);
            rsp_valid <= done_ok || done_err;
            rsp_err   <= done_err;
            if (done_ok) begin
                rsp_rdata <= wr_q ? 8'h00 : D_IN;
            end else if (done_err) begin
                rsp_rdata <= 8'h00;
            end
        end
    end

endmodule
